// File: rtl/pow_pkg.sv
// Shared types, defaults and the toy hash used by the nonce search engine.
package pow_pkg;

  localparam int POW_W = 8;
  localparam logic [POW_W-1:0] POW_SALT = 8'h5A;
  localparam int HASH_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pow_state_e;

  // H(n) = rotl3(data ^ n) + (n ^ salt), all within the low w bits.
  // Width-generic so any instance width up to HASH_MAX_W shares one definition.
  function automatic logic [HASH_MAX_W-1:0] hash_f(
    input logic [HASH_MAX_W-1:0] data,
    input logic [HASH_MAX_W-1:0] nonce,
    input logic [HASH_MAX_W-1:0] salt,
    input int                    w
  );
    logic [HASH_MAX_W-1:0] mask;
    logic [HASH_MAX_W-1:0] x;
    logic [HASH_MAX_W-1:0] rot;
    mask   = {HASH_MAX_W{1'b1}} >> (HASH_MAX_W - w);
    x      = (data ^ nonce) & mask;
    rot    = ((x << 3) | (x >> (w - 3))) & mask;
    hash_f = (rot + ((nonce ^ salt) & mask)) & mask;
  endfunction

endpackage

// File: rtl/pow_hash_stage.sv
// Single registered hash stage: captures H(nonce) alongside its nonce.
module pow_hash_stage
  import pow_pkg::*;
#(
  parameter int             W    = POW_W,
  parameter logic [W-1:0]   SALT = POW_SALT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] data_i,
  input  logic [W-1:0] nonce_i,
  input  logic         valid_i,
  output logic [W-1:0] pipe_hash_o,
  output logic [W-1:0] pipe_nonce_o,
  output logic         pipe_v_o
);

  logic [W-1:0] pipe_hash_d, pipe_hash_q;
  logic [W-1:0] pipe_nonce_d, pipe_nonce_q;
  logic         pipe_v_d, pipe_v_q;

  // Load a new hash only on valid issue; contents hold otherwise so the
  // last nonce is still readable while the controller drains.
  always_comb begin
    pipe_hash_d  = pipe_hash_q;
    pipe_nonce_d = pipe_nonce_q;
    pipe_v_d     = valid_i;
    if (valid_i) begin
      pipe_hash_d  = W'(hash_f(HASH_MAX_W'(data_i), HASH_MAX_W'(nonce_i),
                               HASH_MAX_W'(SALT), W));
      pipe_nonce_d = nonce_i;
    end
  end

  // Pipe register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_hash_q  <= '0;
      pipe_nonce_q <= '0;
      pipe_v_q     <= 1'b0;
    end else begin
      pipe_hash_q  <= pipe_hash_d;
      pipe_nonce_q <= pipe_nonce_d;
      pipe_v_q     <= pipe_v_d;
    end
  end

  assign pipe_hash_o  = pipe_hash_q;
  assign pipe_nonce_o = pipe_nonce_q;
  assign pipe_v_o     = pipe_v_q;

endmodule

// File: rtl/pow_nonce_search.sv
// Toy proof-of-work nonce search: sweeps nonces 0..MAX_NONCE through a
// one-stage hash pipe and reports the first hash strictly below target.
//
// state | meaning
// IDLE  | waiting for start_i; busy_o low
// RUN   | issuing nonces into the pipe, checking the previous one
// DRAIN | all nonces issued; checking the last one in the pipe
// DONE  | one-cycle done_o pulse, result outputs valid
module pow_nonce_search
  import pow_pkg::*;
#(
  parameter int           W         = POW_W,
  parameter int           MAX_NONCE = 255,
  parameter logic [W-1:0] SALT      = POW_SALT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [W-1:0] data_i,
  input  logic [W-1:0] target_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         found_o,
  output logic [W-1:0] nonce_o,
  output logic [W-1:0] hash_o
);

  localparam logic [W-1:0] LAST_NONCE = W'(MAX_NONCE);

  pow_state_e   state_d, state_q;
  logic [W-1:0] data_d, data_q;
  logic [W-1:0] target_d, target_q;
  logic [W-1:0] issue_d, issue_q;
  logic         busy_d, busy_q;
  logic         done_d, done_q;
  logic         found_d, found_q;
  logic [W-1:0] nonce_d, nonce_q;
  logic [W-1:0] hash_d, hash_q;

  logic [W-1:0] pipe_hash;
  logic [W-1:0] pipe_nonce;
  logic         pipe_v;
  logic         pipe_hit;

  pow_hash_stage #(
    .W    (W),
    .SALT (SALT)
  ) u_hash_stage (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_q),
    .nonce_i      (issue_q),
    .valid_i      (state_q == RUN),
    .pipe_hash_o  (pipe_hash),
    .pipe_nonce_o (pipe_nonce),
    .pipe_v_o     (pipe_v)
  );

  assign pipe_hit = (pipe_hash < target_q);

  // Next-state, issue counter and result capture; a hit in RUN wins over
  // advancing, so the nonce issued on that same edge is simply discarded.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    target_d = target_q;
    issue_d  = issue_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    found_d  = found_q;
    nonce_d  = nonce_q;
    hash_d   = hash_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start_i) begin
          data_d   = data_i;
          target_d = target_i;
          issue_d  = '0;
          busy_d   = 1'b1;
          found_d  = 1'b0;
          nonce_d  = '0;
          hash_d   = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (pipe_v && pipe_hit) begin
          found_d = 1'b1;
          nonce_d = pipe_nonce;
          hash_d  = pipe_hash;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (issue_q == LAST_NONCE) begin
          state_d = DRAIN;
        end else begin
          issue_d = issue_q + W'(1);
        end
      end
      DRAIN: begin
        found_d = pipe_hit;
        nonce_d = pipe_hit ? pipe_nonce : LAST_NONCE;
        hash_d  = pipe_hash;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state and registered outputs with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      target_q <= '0;
      issue_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      nonce_q  <= '0;
      hash_q   <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      target_q <= target_d;
      issue_q  <= issue_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      nonce_q  <= nonce_d;
      hash_q   <= hash_d;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign found_o = found_q;
  assign nonce_o = nonce_q;
  assign hash_o  = hash_q;

endmodule

// File: tb/tb_pow_nonce_search.sv
// Scoreboard bench for pow_nonce_search: default instance plus a
// MAX_NONCE=3 instance for the exhaustion case.
module tb_pow_nonce_search;

  typedef struct {
    logic       found;
    logic [7:0] nonce;
    logic [7:0] hash;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start3;
  logic [7:0] data, target;
  logic       busy0, done0, found0;
  logic [7:0] nonce0, hash0;
  logic       busy3, done3, found3;
  logic [7:0] nonce3, hash3;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pow_nonce_search dut (
    .clk(clk), .rst(rst), .start_i(start0), .data_i(data), .target_i(target),
    .busy_o(busy0), .done_o(done0), .found_o(found0), .nonce_o(nonce0), .hash_o(hash0)
  );

  pow_nonce_search #(.MAX_NONCE(3)) dut3 (
    .clk(clk), .rst(rst), .start_i(start3), .data_i(data), .target_i(target),
    .busy_o(busy3), .done_o(done3), .found_o(found3), .nonce_o(nonce3), .hash_o(hash3)
  );

  function automatic logic [7:0] hb(input logic [7:0] d, input logic [7:0] n);
    logic [7:0] x;
    logic [7:0] r;
    x = d ^ n;
    r = {x[4:0], x[7:5]};
    return r + (n ^ 8'h5A);
  endfunction

  function automatic exp_t model(input logic [7:0] d, input logic [7:0] t, input int max);
    exp_t       e;
    logic [7:0] h;
    for (int n = 0; n <= max; n++) begin
      h = hb(d, 8'(n));
      if (h < t) begin
        e.found = 1'b1; e.nonce = 8'(n); e.hash = h; e.lat = n + 2;
        return e;
      end
    end
    e.found = 1'b0; e.nonce = 8'(max); e.hash = hb(d, 8'(max)); e.lat = max + 2;
    return e;
  endfunction

  // Drives one search on the selected instance and observes it; no checking.
  task automatic run_search(input bit sel, input logic [7:0] d, input logic [7:0] t,
                            input bit perturb,
                            output logic f, output logic [7:0] n, output logic [7:0] h,
                            output int lat, output int busy_cyc, output int done_cnt,
                            output bit timeout);
    logic b, dn;
    @(posedge clk); #1;
    data = d; target = t;
    if (sel) start3 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start3 = 1'b0;
    lat = -1; busy_cyc = 0; done_cnt = 0; timeout = 1'b0;
    f = 1'b0; n = '0; h = '0;
    if (perturb) begin
      if (sel) start3 = 1'b1; else start0 = 1'b1;
      data = ~d; target = 8'hFF;
    end
    b = sel ? busy3 : busy0;
    if (b) busy_cyc++;
    for (int k = 1; k < 600; k++) begin
      @(posedge clk); #1;
      b  = sel ? busy3 : busy0;
      dn = sel ? done3 : done0;
      if (b) busy_cyc++;
      if (dn) begin
        done_cnt++;
        if (lat < 0) begin
          lat = k;
          f = sel ? found3 : found0;
          n = sel ? nonce3 : nonce0;
          h = sel ? hash3 : hash0;
        end
      end
      if (perturb && k == 2) begin start0 = 1'b0; start3 = 1'b0; end
      if (lat >= 0 && k >= lat + 3) break;
    end
    if (lat < 0) timeout = 1'b1;
    start0 = 1'b0; start3 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start0 = 1'b0; start3 = 1'b0; data = '0; target = '0;
    #12;
    checks++; if (busy0 !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    checks++; if (done0 !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b exp=0", done0); end
    checks++; if (found0 !== 1'b0) begin failures++; $display("FAIL reset_found got=%b exp=0", found0); end
    checks++; if (nonce0 !== 8'h00) begin failures++; $display("FAIL reset_nonce got=%h exp=00", nonce0); end
    checks++; if (hash0 !== 8'h00) begin failures++; $display("FAIL reset_hash got=%h exp=00", hash0); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic check_result(input string name, input bit sel, input logic [7:0] d,
                              input logic [7:0] t, input bit perturb);
    exp_t e; logic f; logic [7:0] n, h; int lat, bc, dc; bit to;
    sb.push_back(model(d, t, sel ? 3 : 255));
    run_search(sel, d, t, perturb, f, n, h, lat, bc, dc, to);
    e = sb.pop_front();
    checks++; if (to) begin failures++; $display("FAIL %s_timeout no done_o seen", name); end
    checks++; if (f !== e.found) begin failures++; $display("FAIL %s_found got=%b exp=%b", name, f, e.found); end
    checks++; if (n !== e.nonce) begin failures++; $display("FAIL %s_nonce got=%h exp=%h", name, n, e.nonce); end
    checks++; if (h !== e.hash)  begin failures++; $display("FAIL %s_hash got=%h exp=%h", name, h, e.hash); end
    checks++; if (lat != e.lat)  begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, e.lat); end
    checks++; if (bc != e.lat + 1) begin failures++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, bc, e.lat + 1); end
    checks++; if (dc != 1) begin failures++; $display("FAIL %s_done_pulses got=%0d exp=1", name, dc); end
  endtask

  task automatic test_immediate_hit();
    check_result("imm_hit", 1'b0, 8'h00, 8'hFF, 1'b0);
    checks++; if (hash0 !== 8'h5A || nonce0 !== 8'h00 || found0 !== 1'b1) begin
      failures++; $display("FAIL imm_hit_held got=%b/%h/%h exp=1/00/5a", found0, nonce0, hash0);
    end
  endtask

  task automatic test_hit_nonce2();
    check_result("hit_n2", 1'b0, 8'hFF, 8'h50, 1'b0);
    checks++; if (nonce0 !== 8'h02 || hash0 !== 8'h47) begin
      failures++; $display("FAIL hit_n2_const got=%h/%h exp=02/47", nonce0, hash0);
    end
  endtask

  task automatic test_boundary();
    check_result("boundary", 1'b0, 8'h00, 8'h5A, 1'b0);
    checks++; if (nonce0 === 8'h00) begin failures++; $display("FAIL boundary_equal_hit got=%h exp=nonzero", nonce0); end
  endtask

  task automatic test_random();
    logic [7:0] d, t;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      t = 8'($urandom_range(16, 255));
      check_result("random", 1'b0, d, t, 1'b0);
    end
  endtask

  task automatic test_exhaust();
    check_result("exhaust", 1'b1, 8'h3C, 8'h00, 1'b0);
  endtask

  task automatic test_ignored_start();
    check_result("ign_start", 1'b0, 8'hFF, 8'h50, 1'b1);
    data = 8'hFF; target = 8'h50;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    data = 8'hFF; target = 8'h00; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      failures++; $display("FAIL midrst_ctrl got=%b/%b exp=0/0", busy0, done0);
    end
    checks++; if (found0 !== 1'b0 || nonce0 !== 8'h00 || hash0 !== 8'h00) begin
      failures++; $display("FAIL midrst_result got=%b/%h/%h exp=0/00/00", found0, nonce0, hash0);
    end
    @(negedge clk); rst = 1'b0;
    check_result("after_rst", 1'b0, 8'h00, 8'hFF, 1'b0);
  endtask

  initial begin
    test_reset();
    test_immediate_hit();
    test_hit_nonce2();
    test_boundary();
    test_random();
    test_exhaust();
    test_ignored_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
